i2s_playback_ctrl: RTL and testbench

Record/playback scheduler for the sample buffer shared between the PDM microphone path and the I2S transmitter.
- Owns the single-port sample RAM address, write enable and write data.
- In RECORD it writes decimated PCM samples.
- In PLAY it prefetches samples from RAM and feeds the I2S transmitter, advancing on each sample-consumed pulse.
- Sits between the PDM decimator, the sample BRAM and the I2S transmitter.

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_playback_ctrl_if.sv | 27 ++
 rtl/i2s_playback_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_i2s_playback_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the PDM capture / I2S playback audio path.
package i2s_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int CLK_FREQ           = 44_000_000;
  localparam int SAMPLE_RATE        = 44_000;
  localparam int CLKS_PER_SAMPLE    = CLK_FREQ / SAMPLE_RATE;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECORD   = 3'd1,
    ST_PREFETCH = 3'd2,
    ST_PLAY     = 3'd3,
    ST_DRAIN    = 3'd4
  } state_e;

endpackage

// File: rtl/i2s_playback_ctrl_if.sv
// Sample-RAM port and I2S transmitter handshake driven by the playback controller.
interface i2s_playback_ctrl_if
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 14
);

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  i2s_start;
  logic [DATA_WIDTH-1:0] i2s_sample;
  logic                  inc_mem;

  modport master (
    output mem_we, mem_addr, mem_wdata, i2s_start, i2s_sample,
    input  mem_rdata, inc_mem
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata, i2s_start, i2s_sample,
    output mem_rdata, inc_mem
  );

endinterface

// File: rtl/i2s_playback_ctrl.sv
// Record/playback scheduler: owns the single-port sample RAM, writes decimated PCM
// while recording and streams it back to the I2S transmitter while playing.
module i2s_playback_ctrl
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rec_btn,
  input  logic                  play_btn,
  input  logic                  loop_en,
  input  logic                  pcm_valid,
  input  logic [DATA_WIDTH-1:0] pcm_data,
  i2s_playback_ctrl_if.master   bus,
  output logic [ADDR_WIDTH:0]   rec_len,
  output logic                  busy,
  output logic [2:0]            state_o
);

  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                state_q, state_nxt;
  logic [ADDR_WIDTH:0]   wr_addr_q, wr_addr_nxt;
  logic [ADDR_WIDTH:0]   rec_len_q, rec_len_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
  logic                  mem_we_q, mem_we_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_nxt;
  logic                  i2s_start_q, i2s_start_nxt;
  logic [DATA_WIDTH-1:0] i2s_sample_q, i2s_sample_nxt;
  logic                  busy_q;
  logic                  ld_p1, ld_nxt;
  logic                  stop_p1, stop_nxt;
  logic                  last_sample;

  assign last_sample = ({1'b0, rd_addr_q} == (rec_len_q - LEN_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= '0;
      rec_len_q    <= '0;
      rd_addr_q    <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      i2s_start_q  <= 1'b0;
      i2s_sample_q <= '0;
      busy_q       <= 1'b0;
      ld_p1        <= 1'b0;
      stop_p1      <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      wr_addr_q    <= wr_addr_nxt;
      rec_len_q    <= rec_len_nxt;
      rd_addr_q    <= rd_addr_nxt;
      mem_addr_q   <= mem_addr_nxt;
      mem_we_q     <= mem_we_nxt;
      mem_wdata_q  <= mem_wdata_nxt;
      i2s_start_q  <= i2s_start_nxt;
      i2s_sample_q <= i2s_sample_nxt;
      busy_q       <= (state_nxt != ST_IDLE);
      ld_p1        <= ld_nxt;
      stop_p1      <= stop_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    wr_addr_nxt    = wr_addr_q;
    rec_len_nxt    = rec_len_q;
    rd_addr_nxt    = rd_addr_q;
    mem_addr_nxt   = mem_addr_q;
    mem_we_nxt     = 1'b0;
    mem_wdata_nxt  = mem_wdata_q;
    i2s_start_nxt  = i2s_start_q;
    i2s_sample_nxt = i2s_sample_q;
    ld_nxt         = 1'b0;
    stop_nxt       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        i2s_start_nxt = 1'b0;
        if (rec_btn) begin
          state_nxt   = ST_RECORD;
          wr_addr_nxt = '0;
        end else if (play_btn && (rec_len_q != '0)) begin
          state_nxt    = ST_PREFETCH;
          rd_addr_nxt  = '0;
          mem_addr_nxt = '0;
          ld_nxt       = 1'b1;
        end
      end

      ST_RECORD: begin
        // A stop requested alongside a sample, or a filled RAM, closes out one
        // cycle after the final write so mem_we never overlaps IDLE.
        if (stop_p1 || wr_addr_q[ADDR_WIDTH]) begin
          state_nxt   = ST_IDLE;
          rec_len_nxt = wr_addr_q;
        end else begin
          if (pcm_valid) begin
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = wr_addr_q[ADDR_WIDTH-1:0];
            mem_wdata_nxt = pcm_data;
            wr_addr_nxt   = wr_addr_q + LEN_ONE;
          end
          if (rec_btn) begin
            if (pcm_valid) begin
              stop_nxt = 1'b1;
            end else begin
              state_nxt   = ST_IDLE;
              rec_len_nxt = wr_addr_q;
            end
          end
        end
      end

      ST_PREFETCH: begin
        if (rec_btn) begin
          state_nxt     = ST_IDLE;
          i2s_start_nxt = 1'b0;
        end else if (ld_p1) begin
          i2s_sample_nxt = bus.mem_rdata;
        end else begin
          state_nxt     = ST_PLAY;
          i2s_start_nxt = 1'b1;
        end
      end

      ST_PLAY: begin
        if (rec_btn) begin
          state_nxt     = ST_IDLE;
          i2s_start_nxt = 1'b0;
        end else begin
          // ---- stage p1: read data for the address issued last cycle ----
          if (ld_p1) begin
            i2s_sample_nxt = bus.mem_rdata;
          end
          // ---- stage p0: issue next read address on sample consumed ----
          if (bus.inc_mem) begin
            if (!last_sample) begin
              rd_addr_nxt  = rd_addr_q + ADDR_ONE;
              mem_addr_nxt = rd_addr_q + ADDR_ONE;
              ld_nxt       = 1'b1;
            end else if (loop_en) begin
              rd_addr_nxt  = '0;
              mem_addr_nxt = '0;
              ld_nxt       = 1'b1;
            end else begin
              state_nxt = ST_DRAIN;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (rec_btn || bus.inc_mem) begin
          state_nxt     = ST_IDLE;
          i2s_start_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt     = ST_IDLE;
        i2s_start_nxt = 1'b0;
      end
    endcase
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.i2s_start  = i2s_start_q;
  assign bus.i2s_sample = i2s_sample_q;
  assign rec_len        = rec_len_q;
  assign busy           = busy_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_i2s_playback_ctrl.sv
// Scoreboard bench for i2s_playback_ctrl with a 16-entry sample RAM model.
module tb_i2s_playback_ctrl;
  import i2s_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rec_btn = 1'b0;
  logic          play_btn = 1'b0;
  logic          loop_en = 1'b0;
  logic          pcm_valid = 1'b0;
  logic [DW-1:0] pcm_data = '0;
  logic [AW:0]   rec_len;
  logic          busy;
  logic [2:0]    state_o;

  i2s_playback_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  i2s_playback_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rec_btn   (rec_btn),
    .play_btn  (play_btn),
    .loop_en   (loop_en),
    .pcm_valid (pcm_valid),
    .pcm_data  (pcm_data),
    .bus       (bus),
    .rec_len   (rec_len),
    .busy      (busy),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_addr];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] sq[$];
  wr_t           mon_w;
  logic [DW-1:0] mon_s;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pcm(input logic [DW-1:0] d, input bit expect_write, input logic [AW-1:0] a);
    wr_t w;
    pcm_valid = 1'b1;
    pcm_data  = d;
    if (expect_write) begin
      w.a = a;
      w.d = d;
      wq.push_back(w);
    end
    tick();
    pcm_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_rec();
    rec_btn = 1'b1;
    tick();
    rec_btn = 1'b0;
  endtask

  task automatic inc_frame(input logic [DW-1:0] exp_sample, input bit scored);
    if (scored) sq.push_back(exp_sample);
    bus.inc_mem = 1'b1;
    tick();
    bus.inc_mem = 1'b0;
    repeat (4) tick();
  endtask

  task automatic start_play();
    play_btn = 1'b1;
    tick();
    play_btn = 1'b0;
    tick();
    tick();
  endtask

  // Writes and transmitter handoffs are scored as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      check_eq("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        mon_w = wq.pop_front();
        check_eq("wr_addr", 32'(bus.mem_addr), 32'(mon_w.a));
        check_eq("wr_data", 32'(bus.mem_wdata), 32'(mon_w.d));
      end
    end
    if (rst_n && bus.inc_mem && (state_o == ST_PLAY)) begin
      check_eq("i2s_expected", 32'(sq.size() != 0), 32'd1);
      if (sq.size() != 0) begin
        mon_s = sq.pop_front();
        check_eq("i2s_seq", 32'(bus.i2s_sample), 32'(mon_s));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inc_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(bus.i2s_start), 32'd0);
    check_eq("rst_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_len", 32'(rec_len), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic recording of five samples
    pulse_rec();
    check_eq("rec_state", 32'(state_o), 32'(ST_RECORD));
    check_eq("rec_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) push_pcm(16'(16'h1111 * (i + 1)), 1'b1, AW'(i));
    pulse_rec();
    check_eq("rec_stop_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("rec_len5", 32'(rec_len), 32'd5);
    check_eq("rec_wq_empty", 32'(wq.size()), 32'd0);

    // Recording into a full RAM stops on its own at the last address
    pulse_rec();
    for (int i = 0; i < 20; i++) push_pcm(16'(16'h0100 + i), (i < 16), AW'(i));
    check_eq("full_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("full_len", 32'(rec_len), 32'd16);
    check_eq("full_wq_empty", 32'(wq.size()), 32'd0);

    // Stop coinciding with a sample still records that sample
    pulse_rec();
    push_pcm(16'h7001, 1'b1, AW'(0));
    begin
      wr_t w;
      w.a = AW'(1);
      w.d = 16'h7002;
      wq.push_back(w);
    end
    pcm_valid = 1'b1;
    pcm_data  = 16'h7002;
    rec_btn   = 1'b1;
    tick();
    pcm_valid = 1'b0;
    rec_btn   = 1'b0;
    repeat (2) tick();
    check_eq("coinc_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("coinc_len", 32'(rec_len), 32'd2);

    // Playback material
    pulse_rec();
    for (int i = 0; i < 5; i++) push_pcm(16'(16'hA000 + i), 1'b1, AW'(i));
    pulse_rec();
    check_eq("pb_len", 32'(rec_len), 32'd5);

    // Playback without loop
    loop_en  = 1'b0;
    play_btn = 1'b1;
    tick();
    play_btn = 1'b0;
    check_eq("pf_state", 32'(state_o), 32'(ST_PREFETCH));
    check_eq("pf_start0", 32'(bus.i2s_start), 32'd0);
    tick();
    check_eq("pf_start1", 32'(bus.i2s_start), 32'd0);
    check_eq("pf_sample", 32'(bus.i2s_sample), 32'hA000);
    tick();
    check_eq("play_start", 32'(bus.i2s_start), 32'd1);
    check_eq("play_state", 32'(state_o), 32'(ST_PLAY));
    sq.push_back(16'hA000);
    bus.inc_mem = 1'b1;
    tick();
    bus.inc_mem = 1'b0;
    check_eq("reload_lat1", 32'(bus.i2s_sample), 32'hA000);
    tick();
    check_eq("reload_lat2", 32'(bus.i2s_sample), 32'hA001);
    repeat (3) tick();
    for (int i = 1; i < 5; i++) inc_frame(16'(16'hA000 + i), 1'b1);
    check_eq("drain_state", 32'(state_o), 32'(ST_DRAIN));
    check_eq("drain_start", 32'(bus.i2s_start), 32'd1);
    check_eq("drain_sample", 32'(bus.i2s_sample), 32'hA004);
    bus.inc_mem = 1'b1;
    tick();
    bus.inc_mem = 1'b0;
    check_eq("end_start", 32'(bus.i2s_start), 32'd0);
    check_eq("end_state", 32'(state_o), 32'(ST_IDLE));

    // Looping playback wraps after the last sample
    loop_en = 1'b1;
    start_play();
    check_eq("loop_start", 32'(bus.i2s_start), 32'd1);
    for (int k = 0; k < 12; k++) inc_frame(16'(16'hA000 + (k % 5)), 1'b1);
    check_eq("loop_still_start", 32'(bus.i2s_start), 32'd1);
    check_eq("loop_state", 32'(state_o), 32'(ST_PLAY));
    check_eq("loop_sq_empty", 32'(sq.size()), 32'd0);

    // Abort playback with the record button
    play_btn = 1'b1;
    tick();
    play_btn = 1'b0;
    check_eq("play_restart_ign", 32'(state_o), 32'(ST_PLAY));
    pulse_rec();
    check_eq("abort_start", 32'(bus.i2s_start), 32'd0);
    check_eq("abort_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("abort_len", 32'(rec_len), 32'd5);
    check_eq("abort_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of playback
    start_play();
    inc_frame(16'hA000, 1'b1);
    inc_frame(16'hA001, 1'b1);
    check_eq("pre_rst_start", 32'(bus.i2s_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_start", 32'(bus.i2s_start), 32'd0);
    check_eq("arst_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("arst_sample", 32'(bus.i2s_sample), 32'd0);
    check_eq("arst_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("arst_len", 32'(rec_len), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    play_btn = 1'b1;
    tick();
    play_btn = 1'b0;
    check_eq("empty_play_ign", 32'(state_o), 32'(ST_IDLE));

    // Simultaneous buttons favour recording
    rec_btn  = 1'b1;
    play_btn = 1'b1;
    tick();
    rec_btn  = 1'b0;
    play_btn = 1'b0;
    check_eq("prio_state", 32'(state_o), 32'(ST_RECORD));
    pulse_rec();
    check_eq("prio_stop", 32'(state_o), 32'(ST_IDLE));
    check_eq("prio_len", 32'(rec_len), 32'd0);

    check_eq("final_wq", 32'(wq.size()), 32'd0);
    check_eq("final_sq", 32'(sq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
